// File: rtl/constraint_sampler.sv
// Rejection sampler: 6-cycle LFSR fill of a 185-bit candidate, 1-cycle external check, retry up to MAX_TRIES.
// Latency: start -> out_valid in 8 cycles on first-try accept, +7 per rejection. Optional stats counter: SAMPLER_STATS_EN.
// Backpressure: the accepted sample is held on cand with out_valid high until out_ready; start is ignored while busy.
module constraint_sampler #(
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter int unsigned MAX_TRIES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [31:0]  seed_in,
  output logic [184:0] cand,
  input  logic         chk_ok,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         fail,
  output logic [15:0]  tries,
  output logic [31:0]  reject_total
);

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [15:0] MAX_T     = MAX_TRIES[15:0];

  // Field layout seen by the constraint checker, var_0 in the LSBs.
  typedef struct packed {
    logic [28:0] var_9;
    logic [15:0] var_8;
    logic [13:0] var_7;
    logic [18:0] var_6;
    logic [17:0] var_5;
    logic [18:0] var_4;
    logic [27:0] var_3;
    logic [3:0]  var_2;
    logic [21:0] var_1;
    logic [15:0] var_0;
  } cand_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    CHECK = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  cand_t       cand_q;
  logic [31:0] lfsr;
  logic [31:0] lfsr_nxt;
  logic [2:0]  gen_cnt;
  logic [15:0] tries_q;
  logic [15:0] tries_inc;
  logic        fail_q;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    lfsr_step = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  assign lfsr_nxt  = lfsr_step(lfsr);
  assign tries_inc = (tries_q == 16'hFFFF) ? tries_q : tries_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = GEN;
      end
      GEN: begin
        if (gen_cnt == 3'd5) state_nxt = CHECK;
      end
      CHECK: begin
        if (chk_ok)                  state_nxt = HOLD;
        else if (tries_inc == MAX_T) state_nxt = IDLE;
        else                         state_nxt = GEN;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr    <= SEED_EFF;
      cand_q  <= '0;
      gen_cnt <= 3'd0;
      tries_q <= 16'd0;
      fail_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tries_q <= 16'd0;
            fail_q  <= 1'b0;
            gen_cnt <= 3'd0;
            if (seed_in != 32'h0) lfsr <= seed_in;
          end
        end
        GEN: begin
          lfsr    <= lfsr_nxt;
          gen_cnt <= (gen_cnt == 3'd5) ? 3'd0 : gen_cnt + 3'd1;
          // The last word only has 25 bits of room; its top 7 LFSR bits are dropped.
          case (gen_cnt)
            3'd0:    cand_q[31:0]    <= lfsr_nxt;
            3'd1:    cand_q[63:32]   <= lfsr_nxt;
            3'd2:    cand_q[95:64]   <= lfsr_nxt;
            3'd3:    cand_q[127:96]  <= lfsr_nxt;
            3'd4:    cand_q[159:128] <= lfsr_nxt;
            3'd5:    cand_q[184:160] <= lfsr_nxt[24:0];
            default: cand_q          <= cand_q;
          endcase
        end
        CHECK: begin
          if (!chk_ok) begin
            tries_q <= tries_inc;
            if (tries_inc == MAX_T) fail_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cand  = cand_q;
  assign tries = tries_q;
  assign fail  = fail_q;

`ifdef SAMPLER_STATS_EN
  logic [31:0] reject_total_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      reject_total_q <= 32'h0;
    end else if (state == CHECK && !chk_ok && reject_total_q != 32'hFFFF_FFFF) begin
      reject_total_q <= reject_total_q + 32'h1;
    end
  end

  assign reject_total = reject_total_q;
`else
  assign reject_total = 32'h0;
`endif

endmodule

// File: tb/tb_constraint_sampler.sv
// Scoreboard bench for constraint_sampler: stimulus queues expected samples, a monitor checks them on out_valid.
module tb_constraint_sampler;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  seed_in;
  logic [184:0] cand;
  logic         chk_ok;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         fail;
  logic [15:0]  tries;
  logic [31:0]  reject_total;

`ifdef SAMPLER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  constraint_sampler #(.SEED(32'h1), .MAX_TRIES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .seed_in(seed_in), .cand(cand),
    .chk_ok(chk_ok), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .fail(fail), .tries(tries), .reject_total(reject_total)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [184:0] c;
    logic [15:0]  t;
    int           lat;
  } exp_t;

  exp_t         exp_q[$];
  int           errors = 0;
  int           checks = 0;
  int           t_start = 0;
  int           valid_rises = 0;
  logic         prev_valid = 1'b0;
  int           mode = 0;  // 0 accept all, 1 accept only target, 2 reject all
  logic [184:0] target = '0;
  logic [31:0]  m_lfsr = 32'h1;

  // Stand-in for the external constraint checker.
  always_comb begin
    chk_ok = 1'b0;
    case (mode)
      0:       chk_ok = 1'b1;
      1:       chk_ok = (cand == target);
      default: chk_ok = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, expv);
    end
  endtask

  task automatic chk_cand(input string nm, input logic [184:0] act, input logic [184:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  task automatic gen_cand(output logic [184:0] c);
    c = '0;
    for (int k = 0; k < 6; k++) begin
      m_lfsr = step(m_lfsr);
      if (k < 5) c[k*32 +: 32] = m_lfsr;
      else       c[184:160]    = m_lfsr[24:0];
    end
  endtask

  task automatic push_exp(input logic [184:0] c, input logic [15:0] t, input int lat);
    exp_t e;
    e.c = c;
    e.t = t;
    e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge of cycle 1.
  task automatic do_start(input logic [31:0] s);
    start   = 1'b1;
    seed_in = s;
    t_start = cyc;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    seed_in = 32'h0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy=1 after %0d cycles, required 0", nm, n);
    end
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: out_valid=0 after %0d cycles, required 1", nm, n);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk_cand({nm, "_cand"}, cand, '0);
    chk({nm, "_out_valid"}, 32'(out_valid), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_fail"}, 32'(fail), 0);
    chk({nm, "_tries"}, 32'(tries), 0);
    chk({nm, "_reject_total"}, reject_total, 0);
  endtask

  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      exp_t e;
      valid_rises++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got out_valid=1, required no pending sample");
      end else begin
        e = exp_q.pop_front();
        chk_cand("mon_cand", cand, e.c);
        chk("mon_tries", 32'(tries), 32'(e.t));
        chk("mon_latency", 32'(cyc - t_start), 32'(e.lat));
      end
    end
    prev_valid = out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [184:0] c;
    int           rises0;
    rst = 1'b1; start = 1'b0; seed_in = 32'h0; out_ready = 1'b1; mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // Test 1: first-try accept from SEED=1.
    m_lfsr = 32'h1;
    gen_cand(c);
    push_exp(c, 16'd0, 8);
    do_start(32'h0);
    chk("t1_busy", 32'(busy), 1);
    wait_idle("t1");
    chk("t1_word0", cand[31:0], 32'h8020_0003);
    chk("t1_word1", cand[63:32], 32'hC030_0002);
    chk("t1_valid_low", 32'(out_valid), 0);
    chk("t1_reject_total", reject_total, 0);

    // Test 2: accept only the third candidate.
    mode = 1;
    gen_cand(c);
    gen_cand(c);
    gen_cand(c);
    target = c;
    push_exp(c, 16'd2, 22);
    do_start(32'h0);
    wait_idle("t2");
    chk("t2_reject_total", reject_total, STATS ? 32'd2 : 32'd0);
    chk("t2_fail", 32'(fail), 0);

    // Test 3: everything rejected, MAX_TRIES=4.
    mode = 2;
    rises0 = valid_rises;
    repeat (4) gen_cand(c);
    do_start(32'h0);
    wait_idle("t3");
    chk("t3_idle_cycle", 32'(cyc - t_start), 29);
    chk("t3_fail", 32'(fail), 1);
    chk("t3_tries", 32'(tries), 4);
    chk("t3_no_valid", 32'(valid_rises - rises0), 0);
    chk_cand("t3_cand_held", cand, c);
    chk("t3_reject_total", reject_total, STATS ? 32'd6 : 32'd0);

    // Test 4: backpressure in HOLD, start ignored while busy.
    mode = 0;
    out_ready = 1'b0;
    m_lfsr = 32'h1234_5678;
    gen_cand(c);
    push_exp(c, 16'd0, 8);
    do_start(32'h1234_5678);
    chk("t4_fail_cleared", 32'(fail), 0);
    chk("t4_tries_cleared", 32'(tries), 0);
    wait_valid("t4");
    start = 1'b1;
    seed_in = 32'hFFFF_0000;
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", 32'(out_valid), 1);
      chk_cand("t4_hold_cand", cand, c);
      @(negedge clk);
    end
    start = 1'b0;
    seed_in = 32'h0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("t4_valid_dropped", 32'(out_valid), 0);
    chk("t4_idle", 32'(busy), 0);
    out_ready = 1'b1;
    gen_cand(c);
    push_exp(c, 16'd0, 8);
    do_start(32'h0);
    wait_idle("t4b");

    // Test 5: reset during GEN cycle 3, then fresh run from 0xDEADBEEF.
    do_start(32'hCAFE_F00D);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("t5_reset");
    rst = 1'b0;
    m_lfsr = 32'hDEAD_BEEF;
    gen_cand(c);
    push_exp(c, 16'd0, 8);
    do_start(32'hDEAD_BEEF);
    wait_idle("t5");
    chk_cand("t5_cand_held", cand, c);
    chk("t5_reject_total", reject_total, 0);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
